// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - sticky request latch feeding an 8-to-3 priority encoder
//
// Optional feature macro: IRQ_DROP_CNT_EN (enables the lost-edge counter on drop_cnt).
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   req_in     in   [N-1:0] raw request lines, rising edge sets pending
//   mask       in   [N-1:0] 1 = request visible to the encoder
//   pend_out   out  [N-1:0] pending & mask, drives encoder din
//   code_in    in   [CW-1:0] encoder code, used only when pend_out != 0
//   irq_valid  out  offer of irq_code is active
//   irq_code   out  [CW-1:0] registered index being offered
//   irq_ready  in   consumer accepts when irq_valid && irq_ready
//   drop_cnt   out  [7:0] saturating count of cycles with lost request edges

module irq_pending_latch #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_in,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  pend_out,
  input  logic [CW-1:0] code_in,
  output logic          irq_valid,
  output logic [CW-1:0] irq_code,
  input  logic          irq_ready,
  output logic [7:0]    drop_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] req_d;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic         handshake;

  assign rise      = req_in & ~req_d;
  assign pend_out  = pending & mask;
  assign handshake = (state == OFFER) && irq_ready;

  // One-hot clear of the bit being serviced; only ever on a handshake.
  always_comb begin
    clr = '0;
    if (handshake) begin
      clr[irq_code] = 1'b1;
    end
  end

  // Set is OR-ed in after the clear so a coincident re-request survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d   <= '0;
      pending <= '0;
    end else begin
      req_d   <= req_in;
      pending <= (pending & ~clr) | rise;
    end
  end

  // The offer FSM. code_in is sampled only when pend_out is non-zero, so an
  // undefined encoder output with no input never lands in irq_code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend_out) begin
            irq_code  <= code_in;
            irq_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ready) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef IRQ_DROP_CNT_EN
  logic       drop_any;
  logic [7:0] drop_q;

  // A rise on a bit that is being cleared this cycle re-arms it, so it is not lost.
  assign drop_any = |(rise & pending & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_any && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - directed scoreboard bench for irq_pending_latch

module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic [7:0] pend_out;
  logic [2:0] code_in;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic       irq_ready;
  logic [7:0] drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  irq_pending_latch #(.N(8), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .pend_out  (pend_out),
    .code_in   (code_in),
    .irq_valid (irq_valid),
    .irq_code  (irq_code),
    .irq_ready (irq_ready),
    .drop_cnt  (drop_cnt)
  );

  // Reference 8-to-3 priority encoder: bit 0 highest, undefined when empty.
  always_comb begin
    code_in = 3'bxxx;
    for (int i = 7; i >= 0; i--) begin
      if (pend_out[i]) code_in = 3'(i);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted grant must match the next expected code.
  always @(negedge clk) begin
    if (rst_n && irq_valid && irq_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", {5'd0, irq_code}, 8'hEE);
      end else begin
        check("grant_code", {5'd0, irq_code}, 8'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_in    = 8'h00;
    mask      = 8'hFF;
    irq_ready = 1'b0;
    #2;
    check("rst_pend",  pend_out, 8'h00);
    check("rst_valid", {7'd0, irq_valid}, 8'h00);
    check("rst_code",  {5'd0, irq_code}, 8'h00);
    check("rst_drop",  drop_cnt, 8'h00);
    #10;
    rst_n = 1'b1;

    // Single request on bit 3
    tick();
    req_in = 8'h08;
    exp_q.push_back(3);
    tick();
    check("t1_pend", pend_out, 8'h08);
    check("t1_valid_early", {7'd0, irq_valid}, 8'h00);
    tick();
    check("t1_valid", {7'd0, irq_valid}, 8'h01);
    check("t1_code", {5'd0, irq_code}, 8'h03);
    irq_ready = 1'b1;
    tick();
    check("t1_clr_pend", pend_out, 8'h00);
    check("t1_clr_valid", {7'd0, irq_valid}, 8'h00);
    irq_ready = 1'b0;
    req_in    = 8'h00;
    tick();

    // Bits 6 and 1 together, ready held high
    req_in    = 8'h42;
    irq_ready = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(6);
    tick();
    check("t2_pend", pend_out, 8'h42);
    tick();
    check("t2_valid_a", {7'd0, irq_valid}, 8'h01);
    check("t2_code_a", {5'd0, irq_code}, 8'h01);
    tick();
    check("t2_gap", {7'd0, irq_valid}, 8'h00);
    check("t2_pend_b", pend_out, 8'h40);
    tick();
    check("t2_code_b", {5'd0, irq_code}, 8'h06);
    tick();
    check("t2_done_valid", {7'd0, irq_valid}, 8'h00);
    check("t2_done_pend", pend_out, 8'h00);
    irq_ready = 1'b0;
    req_in    = 8'h00;
    tick();

    // Masked request on bit 0
    mask   = 8'hFE;
    req_in = 8'h01;
    tick();
    tick();
    tick();
    check("t3_masked_pend", pend_out, 8'h00);
    check("t3_masked_valid", {7'd0, irq_valid}, 8'h00);
    mask = 8'hFF;
    exp_q.push_back(0);
    #1;
    check("t3_unmask_pend", pend_out, 8'h01);
    tick();
    check("t3_valid", {7'd0, irq_valid}, 8'h01);
    check("t3_code", {5'd0, irq_code}, 8'h00);
    irq_ready = 1'b1;
    tick();
    check("t3_clr", {7'd0, irq_valid}, 8'h00);
    irq_ready = 1'b0;
    req_in    = 8'h00;
    tick();

    // Higher-priority arrival during an offer does not retract it
    req_in = 8'h20;
    exp_q.push_back(5);
    exp_q.push_back(2);
    tick();
    tick();
    check("t4_code5", {5'd0, irq_code}, 8'h05);
    req_in = 8'h24;
    tick();
    check("t4_hold_a", {5'd0, irq_code}, 8'h05);
    tick();
    check("t4_hold_b", {5'd0, irq_code}, 8'h05);
    check("t4_pend", pend_out, 8'h24);
    irq_ready = 1'b1;
    tick();
    check("t4_acc5", {7'd0, irq_valid}, 8'h00);
    check("t4_pend2", pend_out, 8'h04);
    tick();
    check("t4_code2", {5'd0, irq_code}, 8'h02);
    tick();
    check("t4_done", {7'd0, irq_valid}, 8'h00);
    irq_ready = 1'b0;
    req_in    = 8'h00;
    tick();

    // Drop counting on bit 4, hidden from the encoder so it is never serviced
    mask   = 8'hEF;
    req_in = 8'h10;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h10;
    tick();
`ifdef IRQ_DROP_CNT_EN
    check("t5_drop1", drop_cnt, 8'd1);
`else
    check("t5_drop1", drop_cnt, 8'd0);
`endif
    for (int i = 0; i < 299; i++) begin
      req_in = 8'h00;
      tick();
      req_in = 8'h10;
      tick();
    end
`ifdef IRQ_DROP_CNT_EN
    check("t5_drop_sat", drop_cnt, 8'd255);
`else
    check("t5_drop_sat", drop_cnt, 8'd0);
`endif
    check("t5_valid", {7'd0, irq_valid}, 8'h00);

    // Asynchronous reset in the middle of an offer
    mask = 8'hFF;
    tick();
    check("t6_offer", {7'd0, irq_valid}, 8'h01);
    check("t6_code", {5'd0, irq_code}, 8'h04);
    #2;
    rst_n  = 1'b0;
    req_in = 8'h00;
    #1;
    check("t6_rst_valid", {7'd0, irq_valid}, 8'h00);
    check("t6_rst_pend", pend_out, 8'h00);
    check("t6_rst_drop", drop_cnt, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_idle", {7'd0, irq_valid}, 8'h00);

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL grants_missing: observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
